// File: rtl/sub_bytes_iter.sv
// Time-multiplexed AES SubBytes engine.
// A 128-bit state is accepted through a valid/ready handshake. It is then
// substituted LANES bytes per cycle, forward or inverse, and the result is
// presented until the downstream side accepts it. The S-box and inverse
// S-box are computed arithmetically: a GF(2^8) inverse plus the FIPS-197
// affine map. This keeps the table logic compact and easy to audit.

package sub_bytes_pkg;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; the inverse of 0 maps to 0 as FIPS-197 requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Rotate a byte left by n bit positions (n in 1..7)
    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

endpackage

// Forward S-box: affine transform applied to the GF inverse
module sbox (
    input  logic [7:0] state,
    output logic [7:0] Sstate
);
    import sub_bytes_pkg::*;

    logic [7:0] inv_s;

    assign inv_s  = gf_inv(state);
    assign Sstate = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
                  ^ rotl8(inv_s, 4) ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the GF inverse
module inv_sbox (
    input  logic [7:0] state,
    output logic [7:0] Sstate
);
    import sub_bytes_pkg::*;

    logic [7:0] aff_s;

    assign aff_s  = rotl8(state, 1) ^ rotl8(state, 3) ^ rotl8(state, 6) ^ 8'h05;
    assign Sstate = gf_inv(aff_s);
endmodule

module sub_bytes_iter #(
    parameter int LANES      = 4,
    parameter int INVERSE_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] message,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] Emessage,
    output logic         busy
);
    localparam int   BEATS    = 16 / LANES;
    localparam int   CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int   LW       = 8 * LANES;
    localparam logic INV_EN_B = (INVERSE_EN != 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          accept_s;
    logic [CW-1:0] cnt_r;
    logic [127:0]  src_r;
    logic [127:0]  res_r;
    logic          mode_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;

    logic [LW-1:0] lane_in_s;
    logic [LW-1:0] fwd_s;
    logic [LW-1:0] inv_s;
    logic [LW-1:0] sub_s;
    logic [127:0]  src_shift_s;
    logic [127:0]  res_shift_s;
    logic          last_beat_s;

    assign lane_in_s   = src_r[127 -: LW];
    assign sub_s       = mode_r ? inv_s : fwd_s;
    assign last_beat_s = (cnt_r == CW'(BEATS - 1));

    // Lane 0 works on the most significant byte of the current slice
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox u_sbox (
            .state  (lane_in_s[LW-1-8*l -: 8]),
            .Sstate (fwd_s[LW-1-8*l -: 8])
        );
        if (INVERSE_EN != 0) begin : g_inv
            inv_sbox u_inv_sbox (
                .state  (lane_in_s[LW-1-8*l -: 8]),
                .Sstate (inv_s[LW-1-8*l -: 8])
            );
        end else begin : g_no_inv
            assign inv_s[LW-1-8*l -: 8] = 8'h00;
        end
    end

    // The single-beat build loads the whole result at once; narrower builds shift
    if (LANES == 16) begin : g_one_beat
        assign src_shift_s = 128'd0;
        assign res_shift_s = sub_s;
    end else begin : g_multi_beat
        assign src_shift_s = {src_r[127-LW:0], {LW{1'b0}}};
        assign res_shift_s = {res_r[127-LW:0], sub_s};
    end

    // Next-state decode; in_ready is only high in IDLE, so IDLE & in_valid is the handshake
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath shift registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            src_r       <= 128'd0;
            res_r       <= 128'd0;
            mode_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (accept_s) begin
                src_r  <= message;
                mode_r <= inv & INV_EN_B;
                cnt_r  <= {CW{1'b0}};
            end else if (state_r == ST_RUN) begin
                src_r <= src_shift_s;
                res_r <= res_shift_s;
                if (!last_beat_s) begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign Emessage  = res_r;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter. Five instances cover LANES = 1, 2, 4,
// 8 and 16. A sixth instance has LANES = 4 and INVERSE_EN = 0. All six
// share clock, reset, message, inv and out_ready. Each instance has its
// own in_valid.
module tb_sub_bytes_iter;

    localparam logic [127:0] VEC_ZERO = 128'h0;
    localparam logic [127:0] VEC_63   = 128'h63636363636363636363636363636363;
    localparam logic [127:0] VEC_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_SB   = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic         clk;
    logic         rst_n;
    logic [5:0]   iv;
    logic [127:0] message;
    logic         inv;
    logic         out_ready;
    wire  [5:0]   ir;
    wire  [5:0]   ov;
    wire  [5:0]   bz;
    wire  [127:0] em [6];

    int total;
    int bad;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << g), .INVERSE_EN(1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .message   (message),
            .inv       (inv),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .Emessage  (em[g]),
            .busy      (bz[g])
        );
    end

    sub_bytes_iter #(.LANES(4), .INVERSE_EN(0)) u_dut_noinv (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[5]),
        .in_ready  (ir[5]),
        .message   (message),
        .inv       (inv),
        .out_valid (ov[5]),
        .out_ready (out_ready),
        .Emessage  (em[5]),
        .busy      (bz[5])
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One complete transfer on instance idx. inv and message are flipped after
    // acceptance, which must have no effect on the result.
    task automatic xfer(input int idx, input logic [127:0] msg, input logic m,
                        input logic [127:0] exp, input int lat);
        int n;
        @(negedge clk);
        check($sformatf("ready_before[%0d]", idx), ir[idx], 1'b1);
        message  = msg;
        inv      = m;
        iv[idx]  = 1'b1;
        @(posedge clk);
        #1;
        iv[idx]  = 1'b0;
        inv      = ~m;
        message  = ~msg;
        n = 0;
        while (!ov[idx] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency[%0d]", idx), n, lat);
        check($sformatf("data[%0d]", idx), em[idx], exp);
        check($sformatf("done_flags[%0d]", idx), {ir[idx], bz[idx]}, 2'b01);
        @(posedge clk);
        #1;
        check($sformatf("after_hs[%0d]", idx), {ir[idx], ov[idx], bz[idx]}, 3'b100);
    endtask

    initial begin
        int cyc;
        int last;
        int nacc;
        int n;
        int beats;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        iv        = 6'b0;
        message   = 128'h0;
        inv       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state of every instance
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rst_flags[%0d]", i), {ir[i], ov[i], bz[i]}, 3'b100);
            check($sformatf("rst_data[%0d]", i), em[i], VEC_ZERO);
        end

        // LANES=4 forward and inverse
        xfer(2, VEC_ZERO, 1'b0, VEC_63, 4);
        xfer(2, VEC_PT, 1'b0, VEC_SB, 4);
        xfer(2, VEC_SB, 1'b1, VEC_PT, 4);
        xfer(2, VEC_63, 1'b1, VEC_ZERO, 4);

        // INVERSE_EN=0 forces forward substitution even with inv=1
        xfer(5, VEC_PT, 1'b1, VEC_SB, 4);
        xfer(5, VEC_ZERO, 1'b1, VEC_63, 4);

        // Lane-count sweep, both directions
        for (int g = 0; g < 5; g++) begin
            xfer(g, VEC_PT, 1'b0, VEC_SB, 16 >> g);
            xfer(g, VEC_SB, 1'b1, VEC_PT, 16 >> g);
        end

        // Backpressure: DONE held, no capture while in_valid toggles
        out_ready = 1'b0;
        @(negedge clk);
        message = VEC_PT;
        inv     = 1'b0;
        iv[2]   = 1'b1;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        n = 0;
        while (!ov[2] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_latency", n, 4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv[2]   = k[0];
            message = {4{k[31:0] ^ 32'hdeadbeef}};
            inv     = ~k[1];
            @(posedge clk);
            #1;
            check($sformatf("bp_flags[%0d]", k), {ir[2], ov[2], bz[2]}, 3'b011);
            check($sformatf("bp_data[%0d]", k), em[2], VEC_SB);
        end
        @(negedge clk);
        iv[2]     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {ir[2], ov[2], bz[2]}, 3'b100);

        // Reset in the middle of RUN, at the edge that would run beat 2
        @(negedge clk);
        message = VEC_PT;
        inv     = 1'b0;
        iv[2]   = 1'b1;
        @(posedge clk);
        #1;
        iv[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrun_busy", {ir[2], ov[2], bz[2]}, 3'b001);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_rst_flags", {ir[2], ov[2], bz[2]}, 3'b100);
        check("midrun_rst_data", em[2], VEC_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(2, VEC_PT, 1'b0, VEC_SB, 4);

        // Back-to-back: acceptances every BEATS+2 cycles with out_ready high
        for (int g = 0; g < 5; g++) begin
            beats = 16 >> g;
            @(negedge clk);
            message = VEC_PT;
            inv     = 1'b0;
            iv[g]   = 1'b1;
            last    = 0;
            nacc    = 0;
            for (cyc = 0; cyc < 200 && nacc < 3; cyc++) begin
                if (ir[g]) begin
                    if (nacc > 0) begin
                        check($sformatf("b2b_gap[%0d]", g), cyc - last, beats + 2);
                    end
                    last = cyc;
                    nacc++;
                end
                if (ov[g]) begin
                    check($sformatf("b2b_data[%0d]", g), em[g], VEC_SB);
                end
                @(negedge clk);
            end
            iv[g] = 1'b0;
            check($sformatf("b2b_count[%0d]", g), nacc, 3);
            repeat (beats + 4) @(negedge clk);
            check($sformatf("b2b_idle[%0d]", g), {ir[g], ov[g], bz[g]}, 3'b100);
            check($sformatf("b2b_last[%0d]", g), em[g], VEC_SB);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
